// File: rtl/sd_reg_arbiter_pkg.sv
// Shared FSM state encoding and requester indices for the SD register arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package sd_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Requester 0 is the SPI config/debug link, requester 1 the playback streamer.
  localparam logic REQ_SPI  = 1'b0;
  localparam logic REQ_PLAY = 1'b1;

endpackage

// File: rtl/sd_reg_arbiter_rr_arb2.sv
// Two-input round-robin picker with a lock override, used in the IDLE decision.
// Latency: purely combinational.
// Backpressure: none; a request that is not picked simply stays pending.
module sd_reg_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       lock_active,
  input  logic       lock_owner,
  output logic       gnt_idx,
  output logic       gnt_vld
);

  // Locked owner is the only candidate; otherwise a tie goes to the non-owner.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_owner;
    if (lock_active) begin
      if (req[lock_owner]) begin
        gnt_vld = 1'b1;
        gnt_idx = lock_owner;
      end
    end else if (req[0] && req[1]) begin
      gnt_vld = 1'b1;
      gnt_idx = ~last_owner;
    end else if (req[0]) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b0;
    end else if (req[1]) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/sd_reg_arbiter.sv
// Shares the SD host controller byte register port between SPI and playback requesters.
// Latency: req sampled at N -> sd_we at N+1 -> ack at N+2+RD_LAT; one access per RD_LAT+3 cycles.
// Backpressure: a requester holds req until its one-cycle ack; the loser simply waits.
module sd_reg_arbiter
  import sd_reg_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_we,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_we,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] sd_addr,
  output logic              sd_we,
  output logic [DATA_W-1:0] sd_data_o,
  input  logic [DATA_W-1:0] sd_data_i,
  output logic              busy,
  output logic              owner
);

  // Wait counter only needs to hold RD_LAT-1; lock counter only LOCK_MAX-1.
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int CNT_W  = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  arb_state_e  state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  lock_cnt;
  logic              lock_active;
  logic              gnt_idx;
  logic              gnt_vld;
  logic              own_lock;

  assign own_lock = (owner == REQ_PLAY) ? r1_lock : r0_lock;

  sd_reg_arbiter_rr_arb2 u_rr (
    .req         ({r1_req, r0_req}),
    .last_owner  (owner),
    .lock_active (lock_active),
    .lock_owner  (owner),
    .gnt_idx     (gnt_idx),
    .gnt_vld     (gnt_vld)
  );

  // Access sequencer: grant, drive the controller, wait out read latency, ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sd_we       <= 1'b0;
      sd_addr     <= '0;
      sd_data_o   <= '0;
      r0_ack      <= 1'b0;
      r1_ack      <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
      busy        <= 1'b0;
      owner       <= 1'b1;
      wait_cnt    <= '0;
      lock_cnt    <= '0;
      lock_active <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner <= gnt_idx;
            busy  <= 1'b1;
            state <= ST_ISSUE;
            if (gnt_idx == REQ_PLAY) begin
              sd_addr   <= r1_addr;
              sd_data_o <= r1_wdata;
              sd_we     <= r1_we;
            end else begin
              sd_addr   <= r0_addr;
              sd_data_o <= r0_wdata;
              sd_we     <= r0_we;
            end
          end
        end
        ST_ISSUE: begin
          // Write strobe lasts exactly the issue cycle; addr/data stay put.
          sd_we    <= 1'b0;
          wait_cnt <= WAIT_W'(RD_LAT - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            // Writes capture too, which keeps both access kinds on one timeline.
            if (owner == REQ_PLAY) begin
              r1_rdata <= sd_data_i;
              r1_ack   <= 1'b1;
            end else begin
              r0_rdata <= sd_data_i;
              r0_ack   <= 1'b1;
            end
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        ST_DONE: begin
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
          // Lock is bounded so the other requester cannot be starved forever.
          if (own_lock && (lock_cnt < CNT_W'(LOCK_MAX - 1))) begin
            lock_active <= 1'b1;
            lock_cnt    <= lock_cnt + CNT_W'(1);
          end else begin
            lock_active <= 1'b0;
            lock_cnt    <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_reg_arbiter.sv
// Directed bench for sd_reg_arbiter: RD_LAT=1/LOCK_MAX=4 instance plus an RD_LAT=3 instance.
// Latency: expected cycles are hand-derived from N -> N+1 strobe -> N+2+RD_LAT ack.
// Backpressure: requesters hold req until ack and drop it in the ack cycle.
module tb_sd_reg_arbiter;

  localparam int RD_LAT_A = 1;
  localparam int RD_LAT_B = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_req, r1_req, r0_req_b, r1_req_b;
  logic [6:0] r0_addr, r1_addr;
  logic       r0_we, r1_we, r0_lock, r1_lock;
  logic [7:0] r0_wdata, r1_wdata, sd_data_i;

  logic       r0_ack, r1_ack, sd_we, busy, owner;
  logic [7:0] r0_rdata, r1_rdata, sd_data_o;
  logic [6:0] sd_addr;

  logic       r0_ack_b, r1_ack_b, sd_we_b, busy_b, owner_b;
  logic [7:0] r0_rdata_b, r1_rdata_b, sd_data_o_b;
  logic [6:0] sd_addr_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sd_reg_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(RD_LAT_A), .LOCK_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_we(r0_we), .r0_wdata(r0_wdata),
    .r0_lock(r0_lock), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_we(r1_we), .r1_wdata(r1_wdata),
    .r1_lock(r1_lock), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .sd_addr(sd_addr), .sd_we(sd_we), .sd_data_o(sd_data_o), .sd_data_i(sd_data_i),
    .busy(busy), .owner(owner)
  );

  sd_reg_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(RD_LAT_B), .LOCK_MAX(16)) u_dut_b (
    .clk(clk), .rst(rst),
    .r0_req(r0_req_b), .r0_addr(r0_addr), .r0_we(r0_we), .r0_wdata(r0_wdata),
    .r0_lock(r0_lock), .r0_ack(r0_ack_b), .r0_rdata(r0_rdata_b),
    .r1_req(r1_req_b), .r1_addr(r1_addr), .r1_we(r1_we), .r1_wdata(r1_wdata),
    .r1_lock(r1_lock), .r1_ack(r1_ack_b), .r1_rdata(r1_rdata_b),
    .sd_addr(sd_addr_b), .sd_we(sd_we_b), .sd_data_o(sd_data_o_b), .sd_data_i(sd_data_i),
    .busy(busy_b), .owner(owner_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n accesses with r0/r1 req held; order[k] is the expected winner of access k.
  task automatic run_grants(input string tag, input int n, input logic [7:0] order);
    int   cyc;
    int   prev;
    logic got;
    cyc  = 0;
    prev = 0;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
        step();
        cyc++;
        if (r0_ack || r1_ack) got = 1'b1;
      end
      check($sformatf("%s_ack_seen%0d", tag, k), {31'd0, got}, 32'd1);
      check($sformatf("%s_winner%0d", tag, k), {31'd0, r1_ack}, {31'd0, order[k]});
      check($sformatf("%s_single_ack%0d", tag, k), {31'd0, r0_ack & r1_ack}, 32'd0);
      check($sformatf("%s_spacing%0d", tag, k), cyc - prev,
            (k == 0) ? (RD_LAT_A + 2) : (RD_LAT_A + 3));
      prev = cyc;
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    step();
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    r0_req = 0; r1_req = 0; r0_req_b = 0; r1_req_b = 0;
    r0_addr = '0; r1_addr = '0; r0_we = 0; r1_we = 0;
    r0_wdata = '0; r1_wdata = '0; r0_lock = 0; r1_lock = 0;
    sd_data_i = '0;
    step(); step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sd_we", {31'd0, sd_we}, 32'd0);
    check("rst_sd_addr", {25'd0, sd_addr}, 32'h00);
    check("rst_sd_data_o", {24'd0, sd_data_o}, 32'h00);
    check("rst_acks", {30'd0, r1_ack, r0_ack}, 32'd0);
    check("rst_rdata", {16'd0, r1_rdata, r0_rdata}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd1);
    check("rst_owner_b", {31'd0, owner_b}, 32'd1);

    // Single write from r0: strobe only in cycle 1, ack in cycle 3
    r0_req = 1; r0_we = 1; r0_addr = 7'h2C; r0_wdata = 8'hA5;
    step();
    check("wr_c1_we", {31'd0, sd_we}, 32'd1);
    check("wr_c1_addr", {25'd0, sd_addr}, 32'h2C);
    check("wr_c1_data", {24'd0, sd_data_o}, 32'hA5);
    check("wr_c1_busy", {31'd0, busy}, 32'd1);
    check("wr_c1_owner", {31'd0, owner}, 32'd0);
    step();
    check("wr_c2_we", {31'd0, sd_we}, 32'd0);
    check("wr_c2_ack", {31'd0, r0_ack}, 32'd0);
    step();
    check("wr_c3_r0_ack", {31'd0, r0_ack}, 32'd1);
    check("wr_c3_r1_ack", {31'd0, r1_ack}, 32'd0);
    check("wr_c3_we", {31'd0, sd_we}, 32'd0);
    r0_req = 0; r0_we = 0;
    step();
    check("wr_c4_ack", {31'd0, r0_ack}, 32'd0);
    check("wr_c4_busy", {31'd0, busy}, 32'd0);
    check("wr_idle_addr_hold", {25'd0, sd_addr}, 32'h2C);

    // Single read from r1: data present during WAIT (cycle 2) is returned
    r1_req = 1; r1_we = 0; r1_addr = 7'h10; sd_data_i = 8'h00;
    step();
    check("rd_c1_we", {31'd0, sd_we}, 32'd0);
    check("rd_c1_addr", {25'd0, sd_addr}, 32'h10);
    check("rd_c1_owner", {31'd0, owner}, 32'd1);
    sd_data_i = 8'h5A;
    step();
    check("rd_c2_we", {31'd0, sd_we}, 32'd0);
    check("rd_c2_ack", {31'd0, r1_ack}, 32'd0);
    step();
    sd_data_i = 8'hFF;
    check("rd_c3_r1_ack", {31'd0, r1_ack}, 32'd1);
    check("rd_c3_r1_rdata", {24'd0, r1_rdata}, 32'h5A);
    check("rd_c3_r0_ack", {31'd0, r0_ack}, 32'd0);
    r1_req = 0;
    step();
    check("rd_rdata_hold", {24'd0, r1_rdata}, 32'h5A);
    check("rd_c4_ack", {31'd0, r1_ack}, 32'd0);

    // Contention without lock: r0, r1, r0, r1
    r0_we = 0; r1_we = 0; r0_addr = 7'h01; r1_addr = 7'h02;
    r0_req = 1; r1_req = 1;
    run_grants("rr", 4, 8'b0000_1010);

    // Lock held by r0 with LOCK_MAX=4: four r0 grants, then r1
    r0_lock = 1;
    r0_req = 1; r1_req = 1;
    run_grants("lock", 5, 8'b0001_0000);
    r0_lock = 0;

    // Reset during WAIT of an r1 read: abort, no ack ever
    r1_req = 1; r1_we = 0; r1_addr = 7'h33;
    step();
    step();
    check("abort_c2_busy", {31'd0, busy}, 32'd1);
    rst = 1;
    step();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sd_we", {31'd0, sd_we}, 32'd0);
    check("abort_ack", {31'd0, r1_ack}, 32'd0);
    check("abort_owner", {31'd0, owner}, 32'd1);
    rst = 0;
    r1_req = 0;
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (r1_ack || busy) seen = 1'b1;
    end
    check("abort_no_late_ack", {31'd0, seen}, 32'd0);

    // RD_LAT=3 read on the second instance: data of the third WAIT cycle, ack at N+5
    r0_req_b = 1; r0_we = 0; r0_addr = 7'h21; sd_data_i = 8'h11;
    step();
    check("lat3_c1_we", {31'd0, sd_we_b}, 32'd0);
    check("lat3_c1_addr", {25'd0, sd_addr_b}, 32'h21);
    check("lat3_c1_busy", {31'd0, busy_b}, 32'd1);
    step();
    step();
    check("lat3_c3_ack", {31'd0, r0_ack_b}, 32'd0);
    step();
    sd_data_i = 8'h33;
    check("lat3_c4_ack", {31'd0, r0_ack_b}, 32'd0);
    step();
    sd_data_i = 8'h77;
    check("lat3_c5_ack", {31'd0, r0_ack_b}, 32'd1);
    check("lat3_c5_rdata", {24'd0, r0_rdata_b}, 32'h33);
    check("lat3_c5_r1_ack", {31'd0, r1_ack_b}, 32'd0);
    r0_req_b = 0;
    step();
    check("lat3_c6_ack", {31'd0, r0_ack_b}, 32'd0);
    check("lat3_rdata_hold", {24'd0, r0_rdata_b}, 32'h33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
